// File: rtl/mole_scheduler.sv
// Whack-a-mole game scheduler: lights a pseudo-random mole, times it on a
// prescaled tick and scores synchronised switch whacks against it.
module mole_scheduler #(
  parameter int TICK_DIV  = 100000,
  parameter int UP_TICKS  = 1000,
  parameter int UP_STEP   = 100,
  parameter int UP_MIN    = 300,
  parameter int GAP_TICKS = 250,
  parameter int LIVES     = 3,
  parameter int WIN_SCORE = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [5:0]  score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        win,
  output logic        hit_pulse,
  output logic        miss_pulse
);

  typedef enum logic [2:0] {IDLE, ARM, SHOW, GAP, OVER} state_t;

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0] UP_INIT   = 16'(UP_TICKS);
  localparam logic [15:0] UP_DEC    = 16'(UP_STEP);
  localparam logic [15:0] UP_FLOOR  = 16'(UP_MIN);
  localparam logic [15:0] GAP_INIT  = 16'(GAP_TICKS);
  localparam logic [5:0]  WIN_PTS   = 6'(WIN_SCORE);
  localparam logic [1:0]  LIFE_INIT = 2'(LIVES);

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [15:0]      sync1_reg, sync2_reg, sync3_reg;
  logic [15:0]      lfsr_reg;
  logic [3:0]       mole_reg, mole_next, mole_pick;
  logic [15:0]      timer_reg, timer_next;
  logic [15:0]      up_time_reg, up_time_next, up_time_dec;
  logic [5:0]       score_reg, score_next, score_inc;
  logic [1:0]       lives_reg, lives_next;
  logic             win_reg, win_next, game_over_reg;
  logic             hit_pulse_reg, hit_next, miss_pulse_reg, miss_next;
  logic [15:0]      led_reg, led_next;
  logic [15:0]      mole_onehot, mole_next_onehot, sw_edge;
  logic             tick, lfsr_fb, mole_hit, wrong_edge;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_decode
      assign mole_onehot[gi]      = (mole_reg == 4'(gi));
      assign mole_next_onehot[gi] = (mole_next == 4'(gi));
    end
  endgenerate

  assign tick       = (pre_reg == PRE_LAST);
  assign sw_edge    = sync2_reg & ~sync3_reg;
  assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign mole_pick  = (lfsr_reg[3:0] == mole_reg) ? mole_reg + 4'd1 : lfsr_reg[3:0];
  assign mole_hit   = |(sw_edge & mole_onehot);
  assign wrong_edge = |(sw_edge & ~mole_onehot);
  assign score_inc  = (score_reg == 6'd63) ? score_reg : score_reg + 6'd1;
  // Compare before subtracting so the floor is applied without wrapping.
  assign up_time_dec = ({1'b0, up_time_reg} >= ({1'b0, UP_FLOOR} + {1'b0, UP_DEC}))
                       ? up_time_reg - UP_DEC : UP_FLOOR;

  always_comb begin
    state_next   = state_reg;
    pre_next     = tick ? '0 : pre_reg + PRE_W'(1);
    mole_next    = mole_reg;
    timer_next   = timer_reg;
    up_time_next = up_time_reg;
    score_next   = score_reg;
    lives_next   = lives_reg;
    win_next     = win_reg;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    if (start) begin
      score_next   = '0;
      lives_next   = LIFE_INIT;
      up_time_next = UP_INIT;
      win_next     = 1'b0;
      state_next   = ARM;
    end else begin
      case (state_reg)
        ARM: begin
          mole_next  = mole_pick;
          timer_next = up_time_reg;
          state_next = SHOW;
        end
        SHOW: begin
          if (mole_hit) begin
            score_next = score_inc;
            hit_next   = 1'b1;
            if (score_inc[2:0] == 3'd0) up_time_next = up_time_dec;
            if (score_inc == WIN_PTS) begin
              state_next = OVER;
              win_next   = 1'b1;
            end else begin
              state_next = GAP;
              timer_next = GAP_INIT;
            end
          end else if (wrong_edge || (tick && timer_reg == 16'd1)) begin
            lives_next = lives_reg - 2'd1;
            miss_next  = 1'b1;
            if (lives_reg == 2'd1) begin
              state_next = OVER;
              win_next   = 1'b0;
            end else begin
              state_next = GAP;
              timer_next = GAP_INIT;
            end
          end else if (tick) begin
            timer_next = timer_reg - 16'd1;
          end
        end
        GAP: begin
          if (tick) begin
            if (timer_reg == 16'd1) state_next = ARM;
            else timer_next = timer_reg - 16'd1;
          end
        end
        default: ;
      endcase
    end
    // Every mole starts on a fresh tick phase.
    if (state_next == ARM) pre_next = '0;
  end

  always_comb begin
    led_next = 16'h0000;
    case (state_next)
      SHOW:    led_next = mole_next_onehot;
      OVER:    led_next = win_next ? 16'hFFFF : 16'h0000;
      default: led_next = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pre_reg        <= '0;
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      sync3_reg      <= '0;
      lfsr_reg       <= 16'hACE1;
      mole_reg       <= '0;
      timer_reg      <= '0;
      up_time_reg    <= UP_INIT;
      score_reg      <= '0;
      lives_reg      <= '0;
      win_reg        <= 1'b0;
      game_over_reg  <= 1'b0;
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
      led_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      pre_reg        <= pre_next;
      sync1_reg      <= sw;
      sync2_reg      <= sync1_reg;
      sync3_reg      <= sync2_reg;
      lfsr_reg       <= {lfsr_reg[14:0], lfsr_fb};
      mole_reg       <= mole_next;
      timer_reg      <= timer_next;
      up_time_reg    <= up_time_next;
      score_reg      <= score_next;
      lives_reg      <= lives_next;
      win_reg        <= win_next;
      game_over_reg  <= (state_next == OVER);
      hit_pulse_reg  <= hit_next;
      miss_pulse_reg <= miss_next;
      led_reg        <= led_next;
    end
  end

  assign led        = led_reg;
  assign score      = score_reg;
  assign lives      = lives_reg;
  assign game_over  = game_over_reg;
  assign win        = win_reg;
  assign hit_pulse  = hit_pulse_reg;
  assign miss_pulse = miss_pulse_reg;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: stimulus queues expected hit/miss
// events, a negedge monitor pops and checks them and the lit mole.
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [15:0] led;
  logic [5:0]  score;
  logic [1:0]  lives;
  logic        game_over, win, hit_pulse, miss_pulse;

  mole_scheduler #(
    .TICK_DIV(4), .UP_TICKS(5), .UP_STEP(1), .UP_MIN(3),
    .GAP_TICKS(2), .LIVES(3), .WIN_SCORE(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sw(sw), .led(led),
    .score(score), .lives(lives), .game_over(game_over), .win(win),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_hit;
    int score;
    int lives;
    int cyc;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  logic [15:0] m_lfsr = 16'hACE1, lfsr_last = 16'hACE1, led_prev = 16'h0000;
  logic [3:0]  prev_mole = 4'd0, cur_mole = 4'd0, mon_m;
  exp_t        mon_e;
  int          mole_cyc = 0, mole_cnt = 0, seen = 0;
  int          sc_m = 0, lv_m = 0, up_m = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference LFSR (taps 16,14,13,11) used to predict each mole.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge clk) begin
    if (rst) prev_mole = 4'd0;
    if (hit_pulse || miss_pulse) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, hit_pulse, miss_pulse}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind", 32'(hit_pulse), 32'(mon_e.is_hit));
        check("pulse_cycle", cyc, mon_e.cyc);
        check("score", 32'(score), mon_e.score);
        check("lives", 32'(lives), mon_e.lives);
      end
    end
    if (led_prev == 16'h0000 && led != 16'h0000 && led != 16'hFFFF) begin
      mon_m = lfsr_last[3:0];
      if (mon_m == prev_mole) mon_m = mon_m + 4'd1;
      check("mole_led", 32'(led), 32'(16'd1 << mon_m));
      prev_mole = mon_m;
      cur_mole  = mon_m;
      mole_cyc  = cyc;
      mole_cnt++;
    end
    led_prev  = led;
    lfsr_last = m_lfsr;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_mole();
    int n = 0;
    while (mole_cnt == seen && n < 100) begin step(); n++; end
    if (mole_cnt == seen) begin
      n_vec++; n_err++;
      $display("FAIL mole_wait: no mole within 100 cycles");
    end
    seen = mole_cnt;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin step(); n++; end
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d expected events never seen", q.size());
      q.delete();
    end
  endtask

  task automatic push_hit(input int c);
    exp_t e;
    sc_m = (sc_m == 63) ? 63 : sc_m + 1;
    if (sc_m % 8 == 0) up_m = (up_m - 1 < 3) ? 3 : up_m - 1;
    e.is_hit = 1'b1; e.score = sc_m; e.lives = lv_m; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_miss(input int c);
    exp_t e;
    lv_m = lv_m - 1;
    e.is_hit = 1'b0; e.score = sc_m; e.lives = lv_m; e.cyc = c;
    q.push_back(e);
  endtask

  // Whack the lit mole, optionally together with a wrong switch.
  task automatic do_hit(input int wrong_ofs, input bit release_sw);
    logic [3:0] w;
    wait_mole();
    w  = cur_mole + 4'(wrong_ofs);
    sw = (16'd1 << cur_mole) | ((wrong_ofs != 0) ? (16'd1 << w) : 16'd0);
    push_hit(cyc + 3);
    wait_drain();
    if (release_sw) begin step(); sw = 16'h0000; end
  endtask

  task automatic do_wrong();
    logic [3:0] w;
    wait_mole();
    w  = cur_mole + 4'd1;
    sw = 16'd1 << w;
    push_miss(cyc + 3);
    wait_drain();
    step();
    sw = 16'h0000;
  endtask

  task automatic do_timeout();
    wait_mole();
    push_miss(mole_cyc + 4 * up_m - 1);
    wait_drain();
  endtask

  // Whack lands on the same edge as the final timeout tick.
  task automatic do_coincident();
    wait_mole();
    while (cyc < mole_cyc + 16) step();
    sw = 16'd1 << cur_mole;
    push_hit(mole_cyc + 19);
    wait_drain();
    step();
    sw = 16'h0000;
  endtask

  task automatic press_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    sc_m = 0; lv_m = 3; up_m = 5;
    check("start_score", 32'(score), 32'd0);
    check("start_lives", 32'(lives), 32'd3);
    check("start_game_over", 32'(game_over), 32'd0);
    check("start_win", 32'(win), 32'd0);
    check("start_led_arm", 32'(led), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_lives"}, 32'(lives), 32'd0);
    check({tag, "_game_over"}, 32'(game_over), 32'd0);
    check({tag, "_win"}, 32'(win), 32'd0);
    check({tag, "_hit"}, 32'(hit_pulse), 32'd0);
    check({tag, "_miss"}, 32'(miss_pulse), 32'd0);
  endtask

  task automatic check_over(input string tag, input int exp_win, input int exp_led);
    check({tag, "_game_over"}, 32'(game_over), 32'd1);
    check({tag, "_win"}, 32'(win), 32'(exp_win));
    check({tag, "_led"}, 32'(led), 32'(exp_led));
  endtask

  initial begin
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    // Game 1: directed hits, wrong whacks, held switch, coincident tick.
    press_start();
    do_hit(0, 1'b1);
    do_hit(5, 1'b1);
    do_wrong();
    do_hit(0, 1'b0);
    do_timeout();
    sw = 16'h0000;
    do_coincident();
    repeat (4) do_hit(0, 1'b1);
    do_timeout();
    check_over("lose1", 0, 16'h0000);
    check("lose1_score", 32'(score), 32'd8);

    // Game 2: never whack.
    press_start();
    repeat (3) do_timeout();
    check_over("lose2", 0, 16'h0000);

    // Game 3: shortened up-time after 8 hits, then a win.
    press_start();
    repeat (8) do_hit(0, 1'b1);
    do_timeout();
    repeat (2) do_hit(0, 1'b1);
    check_over("win", 1, 16'hFFFF);
    check("win_score", 32'(score), 32'd10);
    check("win_lives", 32'(lives), 32'd2);
    press_start();

    // Reset lands on the edge that would have scored a hit.
    wait_mole();
    sw = 16'd1 << cur_mole;
    step();
    step();
    rst = 1'b1;
    step();
    check_zero("rst_hit");
    step();
    rst = 1'b0;
    sw  = 16'h0000;
    repeat (6) step();
    check_zero("idle_after_rst");

    check("leftover_events", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 100000: clk cycles per game tick (1 ms at 100 MHz).
REQ-002 Parameter UP_TICKS, default 1000: initial ticks a mole stays lit.
REQ-003 Parameter UP_STEP, default 100: up-time reduction applied per 8 points scored.
REQ-004 Parameter UP_MIN, default 300: floor on up-time.
REQ-005 Parameter GAP_TICKS, default 250: dark ticks between moles.
REQ-006 Parameter LIVES, default 3 (1..3): lives granted at game start.
REQ-007 Parameter WIN_SCORE, default 60: score that ends the game as a win.
REQ-008 clk  in  1  system clock; all state changes on the rising edge.
REQ-009 rst  in  1  reset: synchronous, active-high.
REQ-010 start  in  1  debounced single-cycle pulse; begins or restarts a game.
REQ-011 sw  in  16  raw asynchronous switch inputs.
REQ-012 led  out  16  mole display, registered.
REQ-013 score  out  6  points in the current game, registered.
REQ-014 lives  out  2  remaining lives, registered.
REQ-015 game_over  out  1  high while in OVER.
REQ-016 win  out  1  high in OVER when WIN_SCORE was reached.
REQ-017 hit_pulse  out  1  one-cycle pulse on each correct whack.
REQ-018 miss_pulse  out  1  one-cycle pulse on each wrong whack or timeout.

Function
REQ-019 Prescaler counter shall count 0..TICK_DIV-1 and wrap, asserting tick for one cycle at TICK_DIV-1. It shall be cleared on entry to ARM.
REQ-020 sw shall pass through a 2-flop synchroniser; edge = sync2 & ~sync3. Only rising edges count as whacks; switch levels and falling edges are ignored.
REQ-021 A 16-bit Fibonacci LFSR shall use taps 16,14,13,11 and seed 16'hACE1. It shall advance every cycle and never reach zero.
REQ-022 In ARM, mole = lfsr[3:0]. If that equals the previous mole, mole = previous+1 mod 16.
REQ-023 The FSM shall have states IDLE, ARM, SHOW, GAP, OVER.
REQ-024 IDLE: led=0, lives=0. On start, clear score, set lives=LIVES, set up_time=UP_TICKS, go to ARM.
REQ-025 ARM: lasts exactly 1 cycle. Latch mole, load timer=up_time, go to SHOW.
REQ-026 SHOW behaviour:
- led is one-hot at the mole position.
- timer decrements on each tick.
- Edge on the mole switch: hit.
- Edge on any other switch with no mole edge in the same cycle: wrong.
- Tick with timer==1 and no edge: timeout.
REQ-027 Hit: score+1 (saturates at 63) and hit_pulse. Then OVER with win=1 if the new score equals WIN_SCORE, else GAP.
REQ-028 Wrong or timeout: lives-1 and miss_pulse. Then OVER with win=0 if the new lives==0, else GAP.
REQ-029 Priority: a hit beats wrong edges in the same cycle, and a hit beats a timeout tick in the same cycle.
REQ-030 On every hit where the new score is a multiple of 8, up_time = max(up_time-UP_STEP, UP_MIN), evaluated without unsigned underflow.
REQ-031 GAP: led=0 and edges are ignored. After GAP_TICKS ticks, go to ARM.
REQ-032 OVER:
- game_over=1; led=16'hFFFF if win, else 16'h0000.
- score and lives hold.
- start performs the same actions as in IDLE and clears win.
REQ-033 start in ARM, SHOW or GAP shall restart the game as in REQ-024, taking priority over a hit or miss in the same cycle.
REQ-034 Latency: a switch that rises before clock edge n is synchronised through edges n and n+1. score or lives update and the pulse assert at edge n+2.

Reset
REQ-035 rst shall force, on the next clk edge:
- state IDLE;
- led=0, score=0, lives=0, game_over=0, win=0, hit_pulse=0, miss_pulse=0;
- lfsr=16'hACE1, prescaler=0, synchroniser flops=0, up_time=UP_TICKS.
REQ-036 rst asserted mid-game shall override start and all events in the same cycle.

Verification (TICK_DIV=4, UP_TICKS=5, UP_STEP=1, UP_MIN=3, GAP_TICKS=2, LIVES=3, WIN_SCORE=10)
REQ-037 rst then start, raise the lit switch within the window -> score=1, hit_pulse for 1 cycle 2 edges after sync, led=0 for 8 cycles, then a new mole different from the previous one.
REQ-038 Never whack -> each mole times out after 20 cycles with miss_pulse. lives goes 3,2,1,0, then game_over=1, win=0, led=0.
REQ-039 Raise a wrong switch and the mole switch in the same cycle -> score+1, lives unchanged. Raise only a wrong switch -> lives-1.
REQ-040 Hit 8 times -> up_time=4; 10 hits -> OVER with win=1 and led=16'hFFFF. start -> score=0, lives=3, state ARM.
REQ-041 Hold a switch high across moles -> no repeated whacks. Hit coincident with the timeout tick -> counted as a hit.
REQ-042 Assert rst during SHOW with a simultaneous hit -> all outputs 0, IDLE next cycle, score not incremented.
